// File: rtl/lsu_mem.sv
// Load/store unit: one req/gnt/rvalid memory transaction per instruction, stalling the pipeline until done.
// Optional MISALIGN_TRAP_EN: misaligned word accesses complete at once with misalign_o instead of touching memory.
module lsu_mem #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   input  logic              load_i,
   input  logic              store_i,
   input  logic              byte_i,
   input  logic              unsigned_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              stall_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [1:0]        mem_be_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              misalign_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R} state_t;

   state_t              r_state, w_next;
   logic                r_we, r_byte, r_unsigned, r_done;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata, r_rdata;
   logic                w_mem_op, w_accept, w_misalign, w_store_done, w_load_done;
   logic [7:0]          w_lane;
   logic [DATA_W-1:0]   w_fmt;

   assign w_mem_op     = valid_i & (load_i | store_i);
   // done_o blocks acceptance so the completing instruction is never issued twice.
   assign w_accept     = (r_state == S_IDLE) & w_mem_op & ~r_done;
   assign w_store_done = (r_state == S_REQ) & mem_gnt_i & r_we;
   assign w_load_done  = (r_state == S_WAIT_R) & mem_rvalid_i;
   assign stall_o      = w_mem_op & ~r_done;
   assign done_o       = r_done;
   assign rdata_o      = r_rdata;

`ifdef MISALIGN_TRAP_EN
   logic r_misalign;
   assign w_misalign = w_accept & ~byte_i & addr_i[0];
   assign misalign_o = r_misalign;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_misalign <= 1'b0;
      else         r_misalign <= w_misalign;
   end
`else
   assign w_misalign = 1'b0;
   assign misalign_o = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept && !w_misalign) w_next = S_REQ;
         S_REQ:    if (mem_gnt_i) w_next = r_we ? S_IDLE : S_WAIT_R;
         S_WAIT_R: if (mem_rvalid_i) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = 2'b00;
      if (r_state == S_REQ) begin
         mem_req_o   = 1'b1;
         mem_we_o    = r_we;
         mem_addr_o  = {r_addr[ADDR_W-1:1], 1'b0};
         mem_wdata_o = r_byte ? {r_wdata[7:0], r_wdata[7:0]} : r_wdata;
         mem_be_o    = r_byte ? (r_addr[0] ? 2'b10 : 2'b01) : 2'b11;
      end
   end

   assign w_lane = r_addr[0] ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
   assign w_fmt  = r_byte ? {{8{~r_unsigned & w_lane[7]}}, w_lane} : mem_rdata_i;

   // Request attributes are captured once so they stay stable across gnt wait states.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_we       <= 1'b0;
         r_byte     <= 1'b0;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else if (w_accept) begin
         r_we       <= store_i & ~load_i;
         r_byte     <= byte_i;
         r_unsigned <= unsigned_i;
         r_addr     <= addr_i;
         r_wdata    <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_done  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_done <= w_store_done | w_load_done | w_misalign;
         if (w_load_done)                    r_rdata <= w_fmt;
         else if (w_store_done | w_misalign) r_rdata <= '0;
      end
   end

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem: directed cases plus randomized traffic against a memory-level reference model.
module tb_lsu_mem;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        valid_i, load_i, store_i, byte_i, unsigned_i;
   logic [15:0] addr_i, wdata_i;
   logic        stall_o, done_o, mem_req_o, mem_we_o, misalign_o;
   logic [15:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic [1:0]  mem_be_o;
   logic        mem_gnt_i, mem_rvalid_i;
   logic [15:0] mem_rdata_i;

   always #5 clk_i = ~clk_i;

   lsu_mem #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .load_i(load_i), .store_i(store_i),
      .byte_i(byte_i), .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o), .mem_req_o(mem_req_o),
      .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .misalign_o(misalign_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
   } req_t;

   typedef struct {
      logic [15:0] rdata;
      logic        mis;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];

   logic [15:0] ref_mem [0:63];
   logic [15:0] slv_mem [0:63];

   // Memory slave: programmable or random gnt / rvalid delays, optional stray handshakes.
   int gnt_cfg = 0, rd_cfg = 0;
   bit stray_en = 0;
   int gnt_wait = 0, rd_wait = 0;
   bit in_req = 0, rd_pend = 0;
   logic [15:0] rd_data;

   initial begin
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
      forever begin
         @(posedge clk_i); #1;
         mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 16'($urandom);
         if (rd_pend) begin
            if (rd_wait == 0) begin
               mem_rvalid_i = 1; mem_rdata_i = rd_data; rd_pend = 0;
            end else rd_wait--;
         end else if (mem_req_o) begin
            if (!in_req) begin
               in_req = 1;
               gnt_wait = (gnt_cfg >= 0) ? gnt_cfg : int'($urandom_range(0, 3));
            end
            if (gnt_wait == 0) begin
               mem_gnt_i = 1; in_req = 0;
               if (mem_we_o) begin
                  if (mem_be_o[0]) slv_mem[mem_addr_o[6:1]][7:0]  = mem_wdata_o[7:0];
                  if (mem_be_o[1]) slv_mem[mem_addr_o[6:1]][15:8] = mem_wdata_o[15:8];
               end else begin
                  rd_pend = 1;
                  rd_wait = (rd_cfg >= 0) ? rd_cfg : int'($urandom_range(0, 2));
                  rd_data = slv_mem[mem_addr_o[6:1]];
               end
            end else begin
               gnt_wait--;
               if (stray_en && $urandom_range(0, 3) == 0) mem_rvalid_i = 1;
            end
         end else if (stray_en && $urandom_range(0, 7) == 0) begin
            mem_gnt_i = 1; mem_rvalid_i = 1;
         end
      end
   end

   // Monitor: compares every presented request and completion against the scoreboard queues.
   int done_cnt = 0, gnt_cnt = 0;
   logic [15:0] last_rdata = 16'h0;

   initial begin
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            check("rst_done", done_o, 0);
            check("rst_req", mem_req_o, 0);
            check("rst_rdata", rdata_o, 0);
            last_rdata = 16'h0;
            continue;
         end
         if (mem_req_o) begin
            if (req_q.size() == 0) flag("unexpected_request");
            else begin
               check("req_we", mem_we_o, req_q[0].we);
               check("req_addr", mem_addr_o, req_q[0].addr);
               check("req_be", mem_be_o, req_q[0].be);
               if (req_q[0].we) check("req_wdata", mem_wdata_o, req_q[0].wdata);
               if (mem_gnt_i) begin
                  void'(req_q.pop_front());
                  gnt_cnt++;
               end
            end
         end
         if (done_o) begin
            done_cnt++;
            if (rsp_q.size() == 0) flag("unexpected_done");
            else begin
               rsp_t r;
               r = rsp_q.pop_front();
               check("done_rdata", rdata_o, r.rdata);
               check("done_misalign", misalign_o, r.mis);
               last_rdata = r.rdata;
            end
         end else begin
            check("rdata_hold", rdata_o, last_rdata);
            check("misalign_idle", misalign_o, 0);
         end
      end
   end

   // Issues one instruction, builds its expected request/response from the memory model, waits for completion.
   task automatic issue(input bit ld, input bit st, input bit byt, input bit uns,
                        input logic [15:0] addr, input logic [15:0] wdata, output int lat);
      req_t rq;
      rsp_t rs;
      bit mis;
      logic [15:0] w;
      logic [7:0] b;
      valid_i = 1; load_i = ld; store_i = st; byte_i = byt; unsigned_i = uns;
      addr_i = addr; wdata_i = wdata;
      lat = -1;
      if (!(ld || st)) begin
         @(negedge clk_i);
         check("nonmem_stall", stall_o, 0);
         check("nonmem_done", done_o, 0);
         @(posedge clk_i); #1;
         return;
      end
      mis = 0;
`ifdef MISALIGN_TRAP_EN
      if (!byt && addr[0]) mis = 1;
`endif
      rs.mis = mis;
      rs.rdata = 16'h0;
      if (!mis) begin
         rq.we    = st && !ld;
         rq.addr  = {addr[15:1], 1'b0};
         rq.be    = byt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
         rq.wdata = byt ? {wdata[7:0], wdata[7:0]} : wdata;
         req_q.push_back(rq);
         if (rq.we) begin
            if (!byt)         ref_mem[addr[6:1]]       = wdata;
            else if (addr[0]) ref_mem[addr[6:1]][15:8] = wdata[7:0];
            else              ref_mem[addr[6:1]][7:0]  = wdata[7:0];
         end else begin
            w = ref_mem[addr[6:1]];
            b = addr[0] ? w[15:8] : w[7:0];
            if (!byt)     rs.rdata = w;
            else if (uns) rs.rdata = {8'h00, b};
            else          rs.rdata = {{8{b[7]}}, b};
         end
      end
      rsp_q.push_back(rs);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk_i);
         if (done_o) begin
            lat = c;
            check("stall_at_done", stall_o, 0);
            break;
         end
         check("stall_busy", stall_o, 1);
      end
      if (lat < 0) flag("done_timeout");
      @(posedge clk_i); #1;
   endtask

   task automatic idle(input int n);
      valid_i = 0; load_i = 1'($urandom); store_i = 1'($urandom);
      addr_i = 16'($urandom); wdata_i = 16'($urandom);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, lat2, d0, g0;
      bit got;
      logic [15:0] v;
      rst_ni = 0; valid_i = 0; load_i = 0; store_i = 0; byte_i = 0; unsigned_i = 0;
      addr_i = 0; wdata_i = 0;
      for (int i = 0; i < 64; i++) begin
         v = 16'($urandom);
         ref_mem[i] = v;
         slv_mem[i] = v;
      end
      repeat (3) @(posedge clk_i);
      #1;
      check("reset_stall", stall_o, 0);
      check("reset_be", mem_be_o, 0);
      rst_ni = 1;
      @(posedge clk_i); #1;

      // Word store, immediate grant.
      gnt_cfg = 0; rd_cfg = 0;
      issue(0, 1, 0, 0, 16'h0010, 16'hBEEF, lat);
      check("store_latency", lat, 2);

      // Byte loads from an odd address, signed then unsigned.
      ref_mem[16] = 16'h80AA; slv_mem[16] = 16'h80AA;
      issue(1, 0, 1, 0, 16'h0021, 16'h0, lat);
      check("byte_load_latency", lat, 3);
      check("byte_load_signed", rdata_o, 16'hFF80);
      issue(1, 0, 1, 1, 16'h0021, 16'h0, lat);
      check("byte_load_unsigned", rdata_o, 16'h0080);
      idle(2);

      // Word load with wait states on both gnt and rvalid.
      gnt_cfg = 3; rd_cfg = 1;
      d0 = done_cnt;
      issue(1, 0, 0, 0, 16'h0010, 16'h0, lat);
      check("wait_latency", lat, 7);
      check("wait_rdata", rdata_o, 16'hBEEF);
      idle(3);
      check("wait_single_done", done_cnt - d0, 1);

      // Back-to-back store then load, valid held high in between.
      gnt_cfg = 0; rd_cfg = 0;
      d0 = done_cnt; g0 = gnt_cnt;
      issue(0, 1, 0, 0, 16'h0004, 16'h1234, lat);
      issue(1, 0, 0, 0, 16'h0004, 16'h0, lat2);
      check("b2b_store_latency", lat, 2);
      check("b2b_load_latency", lat2, 3);
      check("b2b_rdata", rdata_o, 16'h1234);
      idle(3);
      check("b2b_requests", gnt_cnt - g0, 2);
      check("b2b_dones", done_cnt - d0, 2);

      // Misaligned word load.
      g0 = gnt_cnt;
      issue(1, 0, 0, 0, 16'h0003, 16'h0, lat);
`ifdef MISALIGN_TRAP_EN
      check("misalign_latency", lat, 1);
      check("misalign_no_request", gnt_cnt - g0, 0);
      check("misalign_rdata", rdata_o, 0);
`else
      check("misalign_aligned_latency", lat, 3);
      check("misalign_aligned_requests", gnt_cnt - g0, 1);
`endif
      idle(2);

      // Reset while waiting for read data; the late rvalid must be ignored.
      gnt_cfg = 0; rd_cfg = 4;
      rq_push_for_reset();
      valid_i = 1; load_i = 1; store_i = 0; byte_i = 0; unsigned_i = 0; addr_i = 16'h0008;
      got = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk_i);
         if (mem_req_o && mem_gnt_i) begin
            got = 1;
            break;
         end
      end
      if (!got) flag("reset_test_gnt_timeout");
      @(posedge clk_i); #2;
      valid_i = 0;
      rst_ni = 0;
      #1;
      check("rst_mid_stall", stall_o, 0);
      check("rst_mid_done", done_o, 0);
      check("rst_mid_rdata", rdata_o, 0);
      check("rst_mid_req", mem_req_o, 0);
      check("rst_mid_we", mem_we_o, 0);
      check("rst_mid_addr", mem_addr_o, 0);
      check("rst_mid_wdata", mem_wdata_o, 0);
      check("rst_mid_be", mem_be_o, 0);
      check("rst_mid_misalign", misalign_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1;
      d0 = done_cnt;
      idle(10);
      check("rst_late_rvalid_done", done_cnt - d0, 0);
      check("rst_idle_req", mem_req_o, 0);
      check("rst_idle_rdata", rdata_o, 0);

      // Randomized traffic with random delays and stray handshakes.
      gnt_cfg = -1; rd_cfg = -1; stray_en = 1;
      for (int i = 0; i < 200; i++) begin
         int kind;
         bit ld, st;
         kind = int'($urandom_range(0, 9));
         ld = (kind < 5) || (kind == 8);
         st = (kind >= 5);
         if (kind == 9) begin
            ld = 0; st = 0;
         end
         issue(ld, st, 1'($urandom), 1'($urandom), 16'($urandom_range(0, 127)), 16'($urandom), lat);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      stray_en = 0;
      idle(8);
      check("req_queue_drained", req_q.size(), 0);
      check("rsp_queue_drained", rsp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // The aborted load still presents one request; only its completion is dropped.
   task automatic rq_push_for_reset();
      req_t rq;
      rq.we = 0; rq.addr = 16'h0008; rq.be = 2'b11; rq.wdata = 16'h0;
      req_q.push_back(rq);
   endtask

endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
- Load/store unit that sits directly downstream of the 16-bit ALU in the execute stage.
- Takes the ALU result as the effective address and rs2 data as store data.
- Runs one data-memory transaction using a req/gnt/rvalid handshake.
- Holds the pipeline with stall_o until the access completes, then returns formatted load data for writeback.

Parameters:
- ADDR_W, 16, width of effective address and memory address
- DATA_W, 16, data word width (fixed 16; two byte lanes)

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  execute-stage instruction valid
- load_i  in  1  instruction is a load
- store_i  in  1  instruction is a store
- byte_i  in  1  byte access (0 = 16-bit word)
- unsigned_i  in  1  byte load is zero-extended (0 = sign-extended)
- addr_i  in  ADDR_W  effective address, from alu_data_o
- wdata_i  in  DATA_W  store data, from rs2_data_i
- stall_o  out  1  hold pipeline
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  DATA_W  formatted load data, valid with done_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable
- mem_addr_o  out  ADDR_W  word-aligned address
- mem_wdata_o  out  DATA_W  write data
- mem_be_o  out  2  byte enables
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_W  read data
- misalign_o  out  1  misaligned word access (MISALIGN_TRAP_EN only; tied 0 otherwise)

Behaviour:
- Reset (asynchronous, any time, including mid-transaction): state IDLE; all outputs 0. An in-flight memory access is abandoned, and a late rvalid after reset is ignored.
- mem_op = valid_i & (load_i | store_i). If load_i and store_i are both set, the op is treated as a load.
- stall_o = mem_op & ~done_o (combinational).
- The pipeline holds its inputs stable while stall_o = 1.
- FSM states: IDLE, REQ, WAIT_R.
- IDLE:
  - Accept when mem_op & ~done_o.
  - On accept, latch op, address, data, size and sign, then go to REQ.
  - Inputs are never re-sampled while done_o = 1; this prevents double issue of the completing instruction.
- REQ:
  - mem_req_o = 1.
  - mem_we_o, mem_addr_o, mem_wdata_o and mem_be_o are held stable until mem_gnt_i.
  - gnt & store: go to IDLE; done_o = 1 next cycle.
  - gnt & load: go to WAIT_R.
  - mem_rvalid_i is ignored in REQ.
- WAIT_R:
  - mem_req_o = 0.
  - On mem_rvalid_i, capture and format data into rdata_o, go to IDLE, and pulse done_o.
- Latency, zero wait states: store = accept cycle + 1 REQ cycle, done_o at cycle 2; load adds 1 cycle, done_o at cycle 3 when rvalid arrives the cycle after gnt. Each memory wait cycle adds one cycle.
- Addressing: mem_addr_o = {addr[ADDR_W-1:1], 1'b0}.
- Word access: mem_be_o = 2'b11, mem_wdata_o = wdata.
- Byte access: mem_be_o = addr[0] ? 2'b10 : 2'b01; mem_wdata_o = {wdata[7:0], wdata[7:0]}.
- Byte load data: the lane is selected by latched addr[0]; bits [15:8] are sign- or zero-extended per unsigned_i.
- Word load data: rdata_o = mem_rdata_i.
- rdata_o holds its value until the next load completes; it is 0 after store completion.
- Misaligned word access (addr[0] = 1, byte_i = 0) without the feature: the access is performed at the aligned address; bit 0 is dropped silently.
- Unsolicited mem_rvalid_i or mem_gnt_i in IDLE is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: a misaligned word access issues no memory request. The FSM goes IDLE→IDLE, and done_o and misalign_o pulse together the cycle after accept. rdata_o = 0, no memory write occurs, and total latency is 1 cycle.
- Undefined: misalign_o is tied 0 and the aligned access is performed as in Behaviour.

Test Plan:
- Word store: addr_i=0x0010, wdata_i=0xBEEF, gnt immediate → REQ cycle shows mem_addr_o=0x0010, mem_be_o=11, mem_wdata_o=0xBEEF, we=1; done_o pulses at cycle 2; stall_o drops at cycle 2.
- Byte load, signed, odd address: addr_i=0x0021, mem_rdata_i=0x80AA, rvalid 1 cycle after gnt → mem_addr_o=0x0020, mem_be_o=10, rdata_o=0xFF80; same with unsigned_i=1 → 0x0080.
- Wait states: word load with gnt delayed 3 cycles and rvalid 2 cycles after gnt → request signals stable throughout; done_o at cycle 7; rdata_o=mem_rdata_i; exactly one done_o pulse.
- Back-to-back: store 0x1234→0x0004, then load 0x0004 with valid_i held high → exactly two requests; the second is accepted the cycle after the first done_o; no duplicate issue.
- Reset mid-load: assert rst_ni=0 in WAIT_R, then release; send a stray rvalid → all outputs 0, state IDLE, no done_o.
- MISALIGN_TRAP_EN: word load addr_i=0x0003 → mem_req_o never asserted; done_o=misalign_o=1 at cycle 1; rdata_o=0. Without the macro → mem_addr_o=0x0002, normal load.
